// File: rtl/traffic_phase_ctrl.sv
// Two-road signal sequencer with pedestrian service and a timer-load side channel.
// Optional night flash mode is built when NIGHT_FLASH_EN is defined.
module traffic_phase_ctrl #(
    parameter logic [3:0] MAIN_GREEN = 4'd8,
    parameter logic [3:0] YELLOW     = 4'd3,
    parameter logic [3:0] ALL_RED    = 4'd1,
    parameter logic [3:0] SIDE_GREEN = 4'd15
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Sensor,
    input  logic       PedReq,
`ifdef NIGHT_FLASH_EN
    input  logic       Night,
`endif
    output logic [1:0] MainSel,
    output logic [1:0] SideSel,
    output logic       Walk,
    output logic       TimerLoad,
    output logic [3:0] TimerD,
    output logic [2:0] Phase
);

    typedef enum logic [2:0] {
        S_MG = 3'd0,
        S_MY = 3'd1,
        S_R1 = 3'd2,
        S_SG = 3'd3,
        S_SY = 3'd4,
`ifdef NIGHT_FLASH_EN
        S_FL = 3'd6,
`endif
        S_R2 = 3'd5
    } phase_e;

    localparam logic [1:0] L_OFF = 2'b00;
    localparam logic [1:0] L_RED = 2'b01;
    localparam logic [1:0] L_YEL = 2'b10;
    localparam logic [1:0] L_GRN = 2'b11;

    // Counter reload value: N-1, with code 15 meaning 21 cycles and 0 meaning 1
    function automatic logic [4:0] n_m1(input logic [3:0] c);
        if (c == 4'd15)     n_m1 = 5'd20;
        else if (c == 4'd0) n_m1 = 5'd0;
        else                n_m1 = {1'b0, c} - 5'd1;
    endfunction

    phase_e     state_q, state_d, nxt;
    logic [4:0] cnt_q, cnt_d;
    logic [1:0] main_q, main_d, side_q, side_d;
    logic       walk_q, walk_d, load_q, load_d, ped_q, ped_d;
    logic [3:0] code_q, code_d;
    logic       go, expired, pend;

    assign expired = (cnt_q == 5'd0);
    assign pend    = ped_q | PedReq;

    always_comb begin
        state_d = state_q;
        nxt     = state_q;
        go      = 1'b0;
        cnt_d   = expired ? 5'd0 : cnt_q - 5'd1;
        main_d  = main_q;
        side_d  = side_q;
        walk_d  = walk_q;
        load_d  = 1'b0;
        code_d  = code_q;
        ped_d   = pend;
        if (state_q == S_SG && load_q) ped_d = PedReq;

        unique case (state_q)
            S_MG: begin
`ifdef NIGHT_FLASH_EN
                if (expired && Night) begin
                    nxt = S_FL;
                    go  = 1'b1;
                end else
`endif
                if (expired && (Sensor || pend)) begin
                    nxt = S_MY;
                    go  = 1'b1;
                end
            end
            S_MY: begin nxt = S_R1; go = expired; end
            S_R1: begin nxt = S_SG; go = expired; end
            S_SG: begin nxt = S_SY; go = expired; end
            S_SY: begin nxt = S_R2; go = expired; end
            S_R2: begin nxt = S_MG; go = expired; end
`ifdef NIGHT_FLASH_EN
            S_FL: begin
                nxt = Night ? S_FL : S_R2;
                go  = expired;
            end
`endif
            default: begin nxt = S_MG; go = 1'b1; end
        endcase

        if (go) begin
            state_d = nxt;
            load_d  = 1'b1;
            walk_d  = 1'b0;
            unique case (nxt)
                S_MG: begin code_d = MAIN_GREEN; main_d = L_GRN; side_d = L_RED; end
                S_MY: begin code_d = YELLOW;     main_d = L_YEL; side_d = L_RED; end
                S_R1: begin code_d = ALL_RED;    main_d = L_RED; side_d = L_RED; end
                S_SG: begin
                    code_d = SIDE_GREEN;
                    main_d = L_RED;
                    side_d = L_GRN;
                    walk_d = pend;
                end
                S_SY: begin code_d = YELLOW;     main_d = L_RED; side_d = L_YEL; end
                S_R2: begin code_d = ALL_RED;    main_d = L_RED; side_d = L_RED; end
`ifdef NIGHT_FLASH_EN
                S_FL: begin
                    code_d = YELLOW;
                    // Each half-period toggles lamps; entry starts on the lit half
                    if (state_q == S_FL && main_q == L_YEL) begin
                        main_d = L_OFF;
                        side_d = L_OFF;
                    end else begin
                        main_d = L_YEL;
                        side_d = L_RED;
                    end
                end
`endif
                default: begin code_d = MAIN_GREEN; main_d = L_GRN; side_d = L_RED; end
            endcase
            cnt_d = n_m1(code_d);
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= S_MG;
            cnt_q   <= n_m1(MAIN_GREEN);
            main_q  <= L_GRN;
            side_q  <= L_RED;
            walk_q  <= 1'b0;
            load_q  <= 1'b0;
            code_q  <= MAIN_GREEN;
            ped_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            main_q  <= main_d;
            side_q  <= side_d;
            walk_q  <= walk_d;
            load_q  <= load_d;
            code_q  <= code_d;
            ped_q   <= ped_d;
        end
    end

    assign MainSel   = main_q;
    assign SideSel   = side_q;
    assign Walk      = walk_q;
    assign TimerLoad = load_q;
    assign TimerD    = code_q;
    assign Phase     = state_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed bench for traffic_phase_ctrl; cycle k is the k-th rising edge after reset release.
module tb_traffic_phase_ctrl;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       Sensor = 1'b0;
    logic       PedReq = 1'b0;
`ifdef NIGHT_FLASH_EN
    logic       Night = 1'b0;
`endif
    logic [1:0] MainSel, SideSel;
    logic       Walk, TimerLoad;
    logic [3:0] TimerD;
    logic [2:0] Phase;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int cnt_a, cnt_b;

    traffic_phase_ctrl dut (
        .Clk(Clk),
        .Rst(Rst),
        .Sensor(Sensor),
        .PedReq(PedReq),
`ifdef NIGHT_FLASH_EN
        .Night(Night),
`endif
        .MainSel(MainSel),
        .SideSel(SideSel),
        .Walk(Walk),
        .TimerLoad(TimerLoad),
        .TimerD(TimerD),
        .Phase(Phase)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        @(negedge Clk);
        cyc++;
    endtask

    task automatic goto(input int c);
        while (cyc < c) step();
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        Rst = 1'b0;
        cyc = 0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_phase"}, Phase, 0);
        chk({tag, "_main"}, MainSel, 3);
        chk({tag, "_side"}, SideSel, 1);
        chk({tag, "_walk"}, Walk, 0);
        chk({tag, "_load"}, TimerLoad, 0);
        chk({tag, "_td"}, TimerD, 8);
    endtask

    initial begin
        // Idle main green with no demand
        do_reset();
        chk_reset_vals("rst");
        cnt_a = 0;
        cnt_b = 0;
        repeat (40) begin
            step();
            if (TimerLoad) cnt_a++;
            if (Phase != 3'd0) cnt_b++;
        end
        chk("idle_loads", cnt_a, 0);
        chk("idle_phase_moves", cnt_b, 0);
        chk("idle_main", MainSel, 3);

        // Full vehicle-triggered cycle
        Sensor = 1'b1;
        do_reset();
        goto(7);
        chk("veh_c7_phase", Phase, 0);
        goto(8);
        chk("veh_c8_phase", Phase, 1);
        chk("veh_c8_load", TimerLoad, 1);
        chk("veh_c8_td", TimerD, 3);
        chk("veh_c8_main", MainSel, 2);
        goto(9);
        chk("veh_c9_load", TimerLoad, 0);
        goto(11);
        chk("veh_c11_phase", Phase, 2);
        chk("veh_c11_td", TimerD, 1);
        goto(12);
        chk("veh_c12_phase", Phase, 3);
        chk("veh_c12_td", TimerD, 15);
        chk("veh_c12_side", SideSel, 3);
        chk("veh_c12_walk", Walk, 0);
        goto(32);
        chk("veh_c32_phase", Phase, 3);
        goto(33);
        chk("veh_c33_phase", Phase, 4);
        chk("veh_c33_side", SideSel, 2);
        goto(36);
        chk("veh_c36_phase", Phase, 5);
        goto(37);
        chk("veh_c37_phase", Phase, 0);
        chk("veh_c37_load", TimerLoad, 1);
        chk("veh_c37_td", TimerD, 8);

        // Single pedestrian pulse
        Sensor = 1'b0;
        do_reset();
        goto(20);
        PedReq = 1'b1;
        step();
        PedReq = 1'b0;
        chk("ped_c21_phase", Phase, 1);
        cnt_a = 0;
        cnt_b = 0;
        while (cyc < 100) begin
            if (Walk) cnt_a++;
            if (TimerLoad && Phase == 3'd3) cnt_b++;
            step();
        end
        chk("ped_walk_cycles", cnt_a, 21);
        chk("ped_side_entries", cnt_b, 1);
        chk("ped_c100_phase", Phase, 0);

        // Pedestrian held through side green entry
        PedReq = 1'b1;
        do_reset();
        goto(8);
        chk("hold_c8_phase", Phase, 1);
        goto(12);
        chk("hold_c12_phase", Phase, 3);
        chk("hold_c12_walk", Walk, 1);
        step();
        PedReq = 1'b0;
        goto(33);
        chk("hold_c33_walk", Walk, 0);
        goto(37);
        chk("hold_c37_phase", Phase, 0);
        goto(44);
        chk("hold_c44_phase", Phase, 0);
        goto(45);
        chk("hold_c45_phase", Phase, 1);
        goto(49);
        chk("hold_c49_phase", Phase, 3);
        chk("hold_c49_walk", Walk, 1);
        goto(90);
        chk("hold_c90_phase", Phase, 0);

        // Asynchronous reset mid side green
        Sensor = 1'b1;
        do_reset();
        goto(20);
        chk("arst_pre_phase", Phase, 3);
        #1 Rst = 1'b1;
        #1 chk_reset_vals("arst");
        @(negedge Clk);
        Rst = 1'b0;
        cyc = 0;
        goto(7);
        chk("arst_c7_phase", Phase, 0);
        goto(8);
        chk("arst_c8_phase", Phase, 1);

`ifdef NIGHT_FLASH_EN
        Sensor = 1'b0;
        Night = 1'b1;
        do_reset();
        goto(8);
        chk("fl_c8_phase", Phase, 6);
        chk("fl_c8_main", MainSel, 2);
        chk("fl_c8_side", SideSel, 1);
        chk("fl_c8_load", TimerLoad, 1);
        chk("fl_c8_td", TimerD, 3);
        goto(11);
        chk("fl_c11_main", MainSel, 0);
        chk("fl_c11_side", SideSel, 0);
        chk("fl_c11_load", TimerLoad, 1);
        goto(14);
        chk("fl_c14_main", MainSel, 2);
        Night = 1'b0;
        goto(16);
        chk("fl_c16_phase", Phase, 6);
        goto(17);
        chk("fl_c17_phase", Phase, 5);
        goto(18);
        chk("fl_c18_phase", Phase, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
